rr_mux_arb: RTL
===============

Name: rr_mux_arb

Overview:
- Parametrised N-channel registered multiplexer with a valid/ready handshake on every input channel and on the output.
- Selects one requesting channel per cycle, using round-robin or fixed priority.
- An optional forced-select mode reproduces plain sel-driven mux behaviour.
- Sits between multiple producers and a single shared consumer as the sequential successor to the combinational mux8.

Parameters:
- WIDTH, 3, data bits per channel.
- N, 8, number of input channels. Legal range is N >= 2.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with lowest index winning.
- CW, $clog2(N), channel index width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N  per-channel request.
- in_data  in  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept. One-hot or zero.
- force_en  in  1  forced-select mode enable.
- force_sel  in  CW  channel index used when force_en=1.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered selected data.
- out_chan  out  CW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset is asynchronous and active-low: assertion takes effect immediately, with no dependence on clk.
- Reset values:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=N-1, so channel 0 has top priority first.
  - in_ready=0 while rst_n=0.
- Load condition: load = !out_valid || out_ready. The output register accepts new data whenever it is empty or draining this cycle.
- Grant (combinational):
  - force_en=1: only channel force_sel is eligible; grant[force_sel] = in_valid[force_sel]. force_sel >= N means no grant.
  - force_en=0, RR=1: first set in_valid bit searching from index last+1 upward, wrapping modulo N.
  - force_en=0, RR=0: lowest-index set in_valid bit.
- Handshake:
  - in_ready[i] = grant[i] & load.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer, at the next rising edge:
  - out_valid=1, out_data=in_data[i], out_chan=i.
  - last=i, but only when force_en=0. Forced transfers do not move the pointer.
- No transfer and out_ready=1: out_valid goes to 0 at the next edge. out_data and out_chan hold their last values.
- Stall: while out_valid=1 and out_ready=0, out_valid, out_data and out_chan are held stable and in_ready is all zero.
- Latency and throughput:
  - One cycle from input transfer to out_valid.
  - Throughput is 1 transfer/cycle when out_ready stays high; a drain and a reload happen in the same edge.
- Fairness (RR=1, force_en=0): with k channels continuously valid, each is granted exactly once in every k consecutive transfers.
- Sources must hold in_valid and in_data stable until accepted. The block does not depend on this, but the bench checks it.
- Reset mid-operation: any in-flight output word is discarded, out_valid drops immediately, and the pointer returns to N-1.
- force_en toggling mid-stream: takes effect on the next grant evaluation. A word already in the output register is unaffected.

Decomposition:
- Shared package: the arbitration mode constants ARB_RR=1 and ARB_FIXED=0.
- One sub-module, rr_pick (parameters N, CW):
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational. Implemented as a double-width request vector with a masked priority search.
- The top level holds the output register, the pointer and the force/fixed muxing.

Test Plan:
- Defaults (N=8, WIDTH=3); in_data channels 0..7 = 001,010,011,100,101,110,111,000; force_en=1, force_sel stepping 0..7, all in_valid=1, out_ready=1 -> out_data equals that channel's value one cycle later; out_chan=force_sel; pointer unchanged.
- RR=1, all 8 channels valid, out_ready=1 -> out_chan sequence 0,1,2,...,7,0 on consecutive cycles; out_valid continuously 1.
- RR=1, in_valid=8'b1000_0100, out_ready=1 -> out_chan alternates 2,7,2,7; in_ready one-hot each cycle.
- RR=0, in_valid=8'b1000_0100 held -> out_chan always 2; channel 7 starves.
- Backpressure: one transfer (channel 3), then out_ready=0 for 5 cycles -> out_data=100 and out_chan=3 held; in_ready=0; then out_ready=1 -> next word loads in the same cycle.
- Reset mid-stream: assert rst_n=0 asynchronously between edges while out_valid=1 -> out_valid=0 immediately; after release, first grant with all channels valid goes to channel 0.

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
// Shared constants for the round-robin registered multiplexer.
package rr_mux_arb_pkg;

    // Arbitration mode selectors for the RR parameter
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_mux_arb_pick.sv
// Rotating priority picker: finds the first request strictly after the
// pointer, wrapping modulo N. A pointer of N-1 turns it into a plain
// lowest-index-wins priority encoder.
module rr_pick #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] index,
    output logic          any
);

    logic [2*N-1:0] dbl;

    assign dbl = {req, req};

    // Masked search over the doubled vector from last+1 up to last+N
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!any && dbl[j] && (j > int'(last)) && (j <= int'(last) + N)) begin
                any = 1'b1;
                if (j >= N) begin
                    index = CW'(j - N);
                end else begin
                    index = CW'(j);
                end
            end
        end
        if (any) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with valid/ready handshakes, round-robin
// or fixed-priority arbitration, and a forced-select override.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int N     = 8,
    parameter int RR    = ARB_RR,
    parameter int CW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic               force_en,
    input  logic [CW-1:0]      force_sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [CW-1:0]      out_chan,
    input  logic               out_ready
);

    logic [CW-1:0]    last;
    logic [CW-1:0]    ptr_eff;
    logic [N-1:0]     pick_grant;
    logic [CW-1:0]    pick_index;
    logic             pick_any;
    logic [N-1:0]     grant;
    logic [CW-1:0]    sel_idx;
    logic [WIDTH-1:0] sel_data;
    logic             load;
    logic             xfer;

    // Fixed priority reuses the rotating picker with the pointer pinned at N-1
    assign ptr_eff = (RR == ARB_RR) ? last : CW'(N - 1);

    rr_pick #(
        .N  (N),
        .CW (CW)
    ) u_pick (
        .req   (in_valid),
        .last  (ptr_eff),
        .grant (pick_grant),
        .index (pick_index),
        .any   (pick_any)
    );

    // Choose between forced selection and the arbiter's decision
    always_comb begin
        grant   = '0;
        sel_idx = '0;
        if (force_en) begin
            for (int i = 0; i < N; i++) begin
                if (force_sel == CW'(i)) begin
                    grant[i] = in_valid[i];
                end
            end
            sel_idx = force_sel;
        end else if (pick_any) begin
            grant   = pick_grant;
            sel_idx = pick_index;
        end
    end

    // Steer the winning channel's data toward the output register
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_idx == CW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign xfer     = (|grant) && load;
    assign in_ready = (rst_n && load) ? grant : '0;

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= CW'(N - 1);
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= sel_idx;
                if (!force_en) begin
                    last <= sel_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
